// File: rtl/soc_mem_arbiter_if.sv
// Bundle of CPU-side request ports and the external memory bus seen by soc_mem_arbiter.
// The slave modport is the arbiter's view; the master modport drives requests and the memory response.
interface soc_mem_arbiter_if #(
    parameter int NPORT = 2,
    parameter int AW    = 24,
    parameter int DW    = 64
);
    logic [NPORT-1:0]    req_i;
    logic [NPORT-1:0]    wr_i;
    logic [NPORT*AW-1:0] ad_i;
    logic [NPORT*DW-1:0] dat_i;
    logic [NPORT-1:0]    ack_o;
    logic                err_o;
    logic [DW-1:0]       dat_o;
    logic                mem_cyc;
    logic                mem_wr;
    logic [AW-1:0]       mem_ad;
    logic [DW-1:0]       mem_dato;
    logic                mem_rdy;
    logic [DW-1:0]       mem_dati;

    modport slave (
        input  req_i, wr_i, ad_i, dat_i, mem_rdy, mem_dati,
        output ack_o, err_o, dat_o, mem_cyc, mem_wr, mem_ad, mem_dato
    );

    modport master (
        output req_i, wr_i, ad_i, dat_i, mem_rdy, mem_dati,
        input  ack_o, err_o, dat_o, mem_cyc, mem_wr, mem_ad, mem_dato
    );
endinterface

// File: rtl/soc_mem_arbiter.sv
// N-port round-robin / fixed-priority arbiter merging CPU requests onto one rdy-handshake memory bus,
// with a bus-timeout path that completes the access with err_o=1 and all-ones read data.
module soc_mem_arbiter #(
    parameter int NPORT     = 2,
    parameter int AW        = 24,
    parameter int DW        = 64,
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    soc_mem_arbiter_if.slave  bus
);
    localparam int GW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [GW-1:0] LAST_RST = GW'(NPORT - 1);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         r_state, w_state_nxt;
    logic [GW-1:0]  r_grant, w_grant_nxt;
    logic [GW-1:0]  r_last_grant, w_last_nxt;
    logic [GW-1:0]  w_sel;
    logic           w_found;
    int             w_idx;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic           r_mem_cyc, w_cyc_nxt;
    logic           r_mem_wr, w_wr_nxt;
    logic           r_err, w_err_nxt;
    logic [AW-1:0]  r_mem_ad, w_ad_nxt;
    logic [DW-1:0]  r_mem_dato, w_dato_nxt;
    logic [DW-1:0]  r_dat_o, w_dat_nxt;
    logic [NPORT-1:0] w_ack;

    // Round-robin scans from last_grant+1; fixed priority scans from port 0. First set bit wins.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NPORT; i++) begin
            w_idx = (PRIO_MODE == 1) ? i : (int'(r_last_grant) + 1 + i) % NPORT;
            if (!w_found && bus.req_i[w_idx]) begin
                w_sel   = GW'(w_idx);
                w_found = 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a hold default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last_grant;
        w_cnt_nxt   = r_cnt;
        w_cyc_nxt   = r_mem_cyc;
        w_wr_nxt    = r_mem_wr;
        w_ad_nxt    = r_mem_ad;
        w_dato_nxt  = r_mem_dato;
        w_dat_nxt   = r_dat_o;
        w_err_nxt   = r_err;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_sel;
                    w_last_nxt  = w_sel;
                    w_wr_nxt    = bus.wr_i[w_sel];
                    w_ad_nxt    = bus.ad_i[int'(w_sel)*AW +: AW];
                    w_dato_nxt  = bus.dat_i[int'(w_sel)*DW +: DW];
                    w_cyc_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_rdy) begin
                    if (!r_mem_wr) w_dat_nxt = bus.mem_dati;
                    w_cyc_nxt   = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = DONE;
                end else if (TIMEOUT != 0 && r_cnt == CNT_LAST) begin
                    w_cyc_nxt   = 1'b0;
                    w_dat_nxt   = '1;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = DONE;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous so mem_cyc drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= LAST_RST;
            r_cnt        <= '0;
            r_mem_cyc    <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_ad     <= '0;
            r_mem_dato   <= '0;
            r_dat_o      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
            r_cnt        <= w_cnt_nxt;
            r_mem_cyc    <= w_cyc_nxt;
            r_mem_wr     <= w_wr_nxt;
            r_mem_ad     <= w_ad_nxt;
            r_mem_dato   <= w_dato_nxt;
            r_dat_o      <= w_dat_nxt;
            r_err        <= w_err_nxt;
        end
    end

    always_comb begin
        w_ack = '0;
        if (r_state == DONE) w_ack[r_grant] = 1'b1;
    end

    assign bus.ack_o    = w_ack;
    assign bus.err_o    = r_err;
    assign bus.dat_o    = r_dat_o;
    assign bus.mem_cyc  = r_mem_cyc;
    assign bus.mem_wr   = r_mem_wr;
    assign bus.mem_ad   = r_mem_ad;
    assign bus.mem_dato = r_mem_dato;
endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Directed bench: two arbiters (2-port round-robin with TIMEOUT=4, 4-port fixed priority with no timeout)
// driven cycle by cycle; expected values are hand-derived from the arbiter's protocol.
module tb_soc_mem_arbiter;
    localparam int AW = 24;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc_cnt;

    always #5 clk = ~clk;

    soc_mem_arbiter_if #(.NPORT(2), .AW(AW), .DW(DW)) a_if ();
    soc_mem_arbiter_if #(.NPORT(4), .AW(AW), .DW(DW)) b_if ();

    soc_mem_arbiter #(.NPORT(2), .AW(AW), .DW(DW), .PRIO_MODE(0), .TIMEOUT(4)) u_rr (
        .clk(clk), .rst_n(rst_n), .bus(a_if)
    );
    soc_mem_arbiter #(.NPORT(4), .AW(AW), .DW(DW), .PRIO_MODE(1), .TIMEOUT(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .bus(b_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        a_if.req_i    = '0;
        a_if.wr_i     = 2'b10;
        a_if.ad_i     = {24'h000100, 24'h000200};
        a_if.dat_i    = {64'h55, 64'h0};
        a_if.mem_rdy  = 1'b0;
        a_if.mem_dati = '0;
        b_if.req_i    = '0;
        b_if.wr_i     = '0;
        b_if.ad_i     = {24'h000130, 24'h000120, 24'h000110, 24'h000100};
        b_if.dat_i    = '0;
        b_if.mem_rdy  = 1'b0;
        b_if.mem_dati = '0;
        tick();
        tick();

        // Reset state
        check("rst_cyc",  a_if.mem_cyc, 0);
        check("rst_wr",   a_if.mem_wr, 0);
        check("rst_ad",   a_if.mem_ad, 0);
        check("rst_dato", a_if.mem_dato, 0);
        check("rst_ack",  a_if.ack_o, 0);
        check("rst_err",  a_if.err_o, 0);
        check("rst_dat",  a_if.dat_o, 0);
        check("rst_ackb", b_if.ack_o, 0);
        rst_n = 1'b1;

        // Single read on port 0, mem_rdy one cycle after mem_cyc
        a_if.req_i = 2'b01;
        tick();
        check("rd_cyc", a_if.mem_cyc, 1);
        check("rd_ad",  a_if.mem_ad, 24'h000200);
        check("rd_wr",  a_if.mem_wr, 0);
        a_if.mem_rdy  = 1'b1;
        a_if.mem_dati = 64'hDEAD_BEEF_0123_4567;
        tick();
        check("rd_ack",     a_if.ack_o, 2'b01);
        check("rd_dat",     a_if.dat_o, 64'hDEAD_BEEF_0123_4567);
        check("rd_err",     a_if.err_o, 0);
        check("rd_cyc_off", a_if.mem_cyc, 0);
        a_if.mem_rdy = 1'b0;
        a_if.req_i   = 2'b00;
        tick();
        check("rd_ack_1cyc", a_if.ack_o, 0);
        a_if.mem_rdy  = 1'b1;
        a_if.mem_dati = 64'h1111;
        tick();
        check("idle_rdy_ack", a_if.ack_o, 0);
        check("idle_rdy_dat", a_if.dat_o, 64'hDEAD_BEEF_0123_4567);
        a_if.mem_rdy = 1'b0;

        // Round-robin with both ports requesting continuously; port 1 writes, port 0 reads
        do_reset();
        a_if.req_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int g;
            g = k % 2;
            tick();
            check("rr_cyc", a_if.mem_cyc, 1);
            check("rr_wr",  a_if.mem_wr, g);
            check("rr_ad",  a_if.mem_ad, (g == 1) ? 24'h000100 : 24'h000200);
            if (g == 1) check("rr_dato", a_if.mem_dato, 64'h55);
            a_if.mem_rdy  = 1'b1;
            a_if.mem_dati = 64'h1000 + 64'(k);
            tick();
            check("rr_ack",  a_if.ack_o, (g == 1) ? 2'b10 : 2'b01);
            check("rr_dat",  a_if.dat_o, 64'h1000 + 64'(k - g));
            check("rr_done_cyc", a_if.mem_cyc, 0);
            a_if.mem_rdy = 1'b0;
            tick();
            check("rr_idle_cyc", a_if.mem_cyc, 0);
            check("rr_idle_ack", a_if.ack_o, 0);
        end
        a_if.req_i = 2'b00;

        // Timeout with mem_rdy held low
        do_reset();
        a_if.req_i = 2'b01;
        tick();
        cyc_cnt = 0;
        for (int i = 0; i < 20 && a_if.mem_cyc; i++) begin
            cyc_cnt++;
            tick();
        end
        check("to_cycles", cyc_cnt, 4);
        check("to_ack",    a_if.ack_o, 2'b01);
        check("to_err",    a_if.err_o, 1);
        check("to_dat",    a_if.dat_o, 64'hFFFF_FFFF_FFFF_FFFF);
        a_if.req_i = 2'b00;
        tick();
        check("to_ack_off", a_if.ack_o, 0);

        // mem_rdy on the 4th BUSY cycle beats the timeout
        a_if.req_i = 2'b01;
        tick();
        tick();
        tick();
        tick();
        check("to_edge_cyc", a_if.mem_cyc, 1);
        a_if.mem_rdy  = 1'b1;
        a_if.mem_dati = 64'hCAFE;
        tick();
        check("to_edge_ack", a_if.ack_o, 2'b01);
        check("to_edge_err", a_if.err_o, 0);
        check("to_edge_dat", a_if.dat_o, 64'hCAFE);
        a_if.mem_rdy = 1'b0;
        a_if.req_i   = 2'b00;
        tick();

        // Reset while BUSY, then both ports pending: port 0 first
        do_reset();
        a_if.req_i = 2'b10;
        tick();
        check("rb_cyc", a_if.mem_cyc, 1);
        check("rb_ad",  a_if.mem_ad, 24'h000100);
        #2 rst_n = 1'b0;
        #1;
        check("rb_async_cyc", a_if.mem_cyc, 0);
        check("rb_async_ack", a_if.ack_o, 0);
        a_if.req_i = 2'b11;
        tick();
        check("rb_no_ack", a_if.ack_o, 0);
        rst_n = 1'b1;
        tick();
        check("rb_first_ad", a_if.mem_ad, 24'h000200);
        a_if.mem_rdy = 1'b1;
        tick();
        check("rb_first_ack", a_if.ack_o, 2'b01);
        a_if.mem_rdy = 1'b0;
        tick();
        tick();
        check("rb_second_ad", a_if.mem_ad, 24'h000100);
        check("rb_second_wr", a_if.mem_wr, 1);
        a_if.mem_rdy = 1'b1;
        tick();
        check("rb_second_ack", a_if.ack_o, 2'b10);
        a_if.mem_rdy = 1'b0;
        a_if.req_i   = 2'b00;
        tick();

        // Fixed priority, 4 ports, req 1010 held: port 1 keeps winning
        b_if.req_i = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("fp_ad", b_if.mem_ad, 24'h000110);
            b_if.mem_rdy = 1'b1;
            tick();
            check("fp_ack", b_if.ack_o, 4'b0010);
            b_if.mem_rdy = 1'b0;
            tick();
        end
        b_if.req_i = 4'b1000;
        tick();
        check("fp_p3_ad", b_if.mem_ad, 24'h000130);
        for (int i = 0; i < 10; i++) tick();
        check("fp_no_timeout_cyc", b_if.mem_cyc, 1);
        check("fp_no_timeout_ack", b_if.ack_o, 0);
        b_if.mem_rdy = 1'b1;
        tick();
        check("fp_p3_ack", b_if.ack_o, 4'b1000);
        check("fp_p3_err", b_if.err_o, 0);
        b_if.mem_rdy = 1'b0;
        b_if.req_i   = 4'b0000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
